// File: rtl/pc_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : pc_sequencer
// Brief    : Fetch-PC controller: sequential bundle advance, prioritised
//            redirects, request hold until accept, post-redirect bubble.
// Revision : 1.0 - initial release
// ============================================================================
module pc_sequencer #(
    parameter logic [31:0] RESET_PC     = 32'h0000_0000,
    parameter int          BUNDLE_BYTES = 8,
    parameter int          FLUSH_CYCLES = 2
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        stall,
    input  logic        fetch_ready,
    input  logic        trap_req,
    input  logic [31:0] trap_vec,
    input  logic        br0_taken,
    input  logic [31:0] br0_target,
    input  logic        br1_taken,
    input  logic [31:0] br1_target,
    output logic [31:0] PC,
    output logic        fetch_valid,
    output logic        flush,
    output logic        redirect_pending
);

    localparam logic [31:0] c_bundle     = 32'(BUNDLE_BYTES);
    localparam logic [3:0]  c_flush_init = 4'(FLUSH_CYCLES - 1);

    typedef enum logic [1:0] {
        S_BOOT   = 2'd0,
        S_RUN    = 2'd1,
        S_HOLD   = 2'd2,
        S_BUBBLE = 2'd3
    } state_t;

    state_t      r_state, w_state_nxt;
    logic [31:0] r_pc, w_pc_nxt;
    logic        r_valid, w_valid_nxt;
    logic        r_flush, w_flush_nxt;
    logic        r_pend, w_pend_nxt;
    logic [31:0] r_pend_tgt, w_pend_tgt_nxt;
    logic [3:0]  r_cnt, w_cnt_nxt;

    logic        w_accept;
    logic        w_redir;
    logic [31:0] w_tgt;
    logic [31:0] w_trap_tgt;
    logic [31:0] w_hold_tgt;

    assign w_accept   = r_valid & fetch_ready & ~stall;
    assign w_redir    = trap_req | br0_taken | br1_taken;
    assign w_trap_tgt = {trap_vec[31:2], 2'b00};
    assign w_tgt      = trap_req  ? w_trap_tgt :
                        br0_taken ? {br0_target[31:2], 2'b00} :
                                    {br1_target[31:2], 2'b00};
    // While a redirect waits, only a trap may replace its target.
    assign w_hold_tgt = trap_req ? w_trap_tgt : r_pend_tgt;

    always_comb begin
        w_state_nxt    = r_state;
        w_pc_nxt       = r_pc;
        w_valid_nxt    = r_valid;
        w_flush_nxt    = 1'b0;
        w_pend_nxt     = r_pend;
        w_pend_tgt_nxt = r_pend_tgt;
        w_cnt_nxt      = r_cnt;
        case (r_state)
            S_BOOT: begin
                w_state_nxt = S_RUN;
                w_valid_nxt = 1'b1;
            end
            S_RUN: begin
                if (w_redir && w_accept) begin
                    w_pc_nxt    = w_tgt;
                    w_flush_nxt = 1'b1;
                    w_valid_nxt = 1'b0;
                    w_cnt_nxt   = c_flush_init;
                    w_state_nxt = S_BUBBLE;
                end else if (w_redir) begin
                    w_pend_tgt_nxt = w_tgt;
                    w_pend_nxt     = 1'b1;
                    w_state_nxt    = S_HOLD;
                end else if (w_accept) begin
                    w_pc_nxt = r_pc + c_bundle;
                end
            end
            S_HOLD: begin
                w_pend_tgt_nxt = w_hold_tgt;
                if (w_accept) begin
                    w_pc_nxt    = w_hold_tgt;
                    w_flush_nxt = 1'b1;
                    w_valid_nxt = 1'b0;
                    w_pend_nxt  = 1'b0;
                    w_cnt_nxt   = c_flush_init;
                    w_state_nxt = S_BUBBLE;
                end
            end
            S_BUBBLE: begin
                if (w_redir) begin
                    w_pc_nxt    = w_tgt;
                    w_flush_nxt = 1'b1;
                    w_cnt_nxt   = c_flush_init;
                end else if (r_cnt == 4'd0) begin
                    w_valid_nxt = 1'b1;
                    w_state_nxt = S_RUN;
                end else begin
                    w_cnt_nxt = r_cnt - 4'd1;
                end
            end
            default: begin
                w_state_nxt = S_BOOT;
                w_valid_nxt = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            r_state    <= S_BOOT;
            r_pc       <= RESET_PC;
            r_valid    <= 1'b0;
            r_flush    <= 1'b0;
            r_pend     <= 1'b0;
            r_pend_tgt <= 32'h0;
            r_cnt      <= 4'd0;
        end else begin
            r_state    <= w_state_nxt;
            r_pc       <= w_pc_nxt;
            r_valid    <= w_valid_nxt;
            r_flush    <= w_flush_nxt;
            r_pend     <= w_pend_nxt;
            r_pend_tgt <= w_pend_tgt_nxt;
            r_cnt      <= w_cnt_nxt;
        end
    end

    assign PC               = r_pc;
    assign fetch_valid      = r_valid;
    assign flush            = r_flush;
    assign redirect_pending = r_pend;

endmodule
`default_nettype wire

// File: tb/tb_pc_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : tb_pc_sequencer
// Brief    : Scoreboard bench for pc_sequencer with a cycle-level reference model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_pc_sequencer;

    localparam logic [31:0] RESET_PC = 32'h0000_0000;
    localparam int          FLUSH    = 2;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        stall = 1'b0;
    logic        fetch_ready = 1'b0;
    logic        trap_req = 1'b0;
    logic [31:0] trap_vec = 32'h0;
    logic        br0_taken = 1'b0;
    logic [31:0] br0_target = 32'h0;
    logic        br1_taken = 1'b0;
    logic [31:0] br1_target = 32'h0;
    logic [31:0] PC;
    logic        fetch_valid;
    logic        flush;
    logic        redirect_pending;

    always #5 clk = ~clk;

    pc_sequencer #(
        .RESET_PC     (RESET_PC),
        .BUNDLE_BYTES (8),
        .FLUSH_CYCLES (FLUSH)
    ) dut (
        .clk              (clk),
        .reset            (reset),
        .stall            (stall),
        .fetch_ready      (fetch_ready),
        .trap_req         (trap_req),
        .trap_vec         (trap_vec),
        .br0_taken        (br0_taken),
        .br0_target       (br0_target),
        .br1_taken        (br1_taken),
        .br1_target       (br1_target),
        .PC               (PC),
        .fetch_valid      (fetch_valid),
        .flush            (flush),
        .redirect_pending (redirect_pending)
    );

    typedef struct packed {
        logic [31:0] pc;
        logic        valid;
        logic        flush;
        logic        pend;
    } exp_t;

    exp_t q[$];
    int   nvec = 0;
    int   nmiss = 0;

    // Reference model: what the fetch unit looks like in the current cycle.
    logic [31:0] m_pc = 32'h0;
    logic [31:0] m_ptgt = 32'h0;
    logic        m_valid = 1'b0;
    logic        m_flush = 1'b0;
    logic        m_pend = 1'b0;
    logic        m_boot = 1'b0;
    int          m_left = 0;

    task automatic model_step();
        logic        acc;
        logic        has;
        logic [31:0] tgt;
        acc = m_valid && fetch_ready && !stall;
        has = trap_req || br0_taken || br1_taken;
        tgt = trap_req ? trap_vec : (br0_taken ? br0_target : br1_target);
        tgt = tgt & 32'hFFFF_FFFC;
        m_flush = 1'b0;
        if (!reset) begin
            m_pc = RESET_PC; m_valid = 1'b0; m_pend = 1'b0;
            m_ptgt = 32'h0; m_left = 0; m_boot = 1'b1;
        end else if (m_boot) begin
            m_boot = 1'b0;
            m_valid = 1'b1;
        end else if (m_valid && m_pend) begin
            if (trap_req) m_ptgt = trap_vec & 32'hFFFF_FFFC;
            if (acc) begin
                m_pc = m_ptgt; m_flush = 1'b1; m_valid = 1'b0;
                m_pend = 1'b0; m_left = FLUSH;
            end
        end else if (m_valid) begin
            if (has && acc) begin
                m_pc = tgt; m_flush = 1'b1; m_valid = 1'b0; m_left = FLUSH;
            end else if (has) begin
                m_pend = 1'b1; m_ptgt = tgt;
            end else if (acc) begin
                m_pc = m_pc + 32'd8;
            end
        end else begin
            if (has) begin
                m_pc = tgt; m_flush = 1'b1; m_left = FLUSH;
            end else begin
                m_left = m_left - 1;
                if (m_left == 0) m_valid = 1'b1;
            end
        end
    endtask

    task automatic cyc(input logic rst_n, input logic st, input logic rdy,
                       input logic tr, input logic [31:0] tv,
                       input logic b0, input logic [31:0] b0t,
                       input logic b1, input logic [31:0] b1t);
        @(negedge clk);
        reset = rst_n; stall = st; fetch_ready = rdy;
        trap_req = tr; trap_vec = tv;
        br0_taken = b0; br0_target = b0t;
        br1_taken = b1; br1_target = b1t;
        model_step();
        q.push_back('{pc: m_pc, valid: m_valid, flush: m_flush, pend: m_pend});
    endtask

    task automatic idle(input int n, input logic rdy);
        for (int i = 0; i < n; i++) cyc(1, 0, rdy, 0, 0, 0, 0, 0, 0);
    endtask

    // Monitor: every cycle the DUT presents a full output vector to check.
    initial begin
        exp_t e;
        forever begin
            @(posedge clk);
            #2;
            if (q.size() > 0) begin
                e = q.pop_front();
                nvec++;
                if (PC !== e.pc || fetch_valid !== e.valid ||
                    flush !== e.flush || redirect_pending !== e.pend) begin
                    nmiss++;
                    $display("FAIL outvec t=%0t: got pc=%h valid=%b flush=%b pend=%b, expected pc=%h valid=%b flush=%b pend=%b",
                             $time, PC, fetch_valid, flush, redirect_pending,
                             e.pc, e.valid, e.flush, e.pend);
                end
            end
        end
    end

    initial begin
        // reset, boot and free run
        for (int i = 0; i < 3; i++) cyc(0, 0, 1, 0, 0, 0, 0, 0, 0);
        idle(6, 1);
        // simultaneous redirects and priority
        cyc(1, 0, 1, 1, 32'h100, 1, 32'h200, 1, 32'h300); idle(3, 1);
        cyc(1, 0, 1, 0, 32'h100, 1, 32'h200, 1, 32'h300); idle(3, 1);
        cyc(1, 0, 1, 0, 0, 0, 0, 1, 32'h300);             idle(3, 1);
        cyc(1, 0, 1, 0, 0, 0, 0, 1, 32'h303);             idle(3, 1);
        // redirect held, branch ignored, trap replaces, then re-redirect in bubble
        cyc(1, 0, 0, 0, 0, 1, 32'h400, 0, 0);
        cyc(1, 0, 0, 0, 0, 1, 32'h500, 0, 0);
        cyc(1, 0, 0, 1, 32'h600, 0, 0, 0, 0);
        idle(1, 0);
        idle(1, 1);
        idle(1, 1);
        cyc(1, 0, 1, 0, 0, 1, 32'h800, 0, 0);
        idle(4, 1);
        // wrap and stall
        cyc(1, 0, 1, 0, 0, 1, 32'hFFFF_FFF8, 0, 0);
        idle(3, 1);
        for (int i = 0; i < 3; i++) cyc(1, 1, 1, 0, 0, 0, 0, 0, 0);
        idle(2, 1);
        // reset while holding, with a simultaneous trap
        cyc(1, 0, 0, 0, 0, 1, 32'h900, 0, 0);
        idle(1, 0);
        cyc(0, 0, 1, 1, 32'hABC, 0, 0, 0, 0);
        idle(5, 1);
        // randomized traffic
        for (int i = 0; i < 3000; i++) begin
            cyc(($urandom_range(0, 199) != 0),
                ($urandom_range(0, 3) == 0),
                ($urandom_range(0, 3) != 0),
                ($urandom_range(0, 19) == 0), $urandom(),
                ($urandom_range(0, 9) == 0), $urandom(),
                ($urandom_range(0, 9) == 0), $urandom());
        end
        repeat (3) @(posedge clk);
        #3;
        if (q.size() != 0) begin
            nmiss++;
            $display("FAIL drain: %0d expected vectors left unchecked, required 0", q.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", nvec, nmiss);
        $finish;
    end

endmodule
`default_nettype wire
